// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_ctrl
// Purpose  : UART receive sequencer: start detect, oversampled bit timing,
//            LSB-first deserialisation, parity/stop checking, result pulses.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  sampled_bit,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  data_sample_en,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  strt_glitch,
    output logic                  busy
);

    localparam int                    c_BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_W-1:0]    c_LAST_BIT = c_BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRESCALE_W-1:0] c_MIN_P    = PRESCALE_W'(8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [PRESCALE_W-1:0]   r_edge_cnt;
    logic [PRESCALE_W-1:0]   r_p;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0]   r_shift;
    logic                    r_par_en;
    logic                    r_par_typ;
    logic                    r_par_fail;

    logic [PRESCALE_W-1:0]   w_p_in;
    logic [PRESCALE_W-1:0]   w_half;
    logic [PRESCALE_W-1:0]   w_check;
    logic [PRESCALE_W-1:0]   w_last;
    logic                    w_check_edge;
    logic                    w_last_edge;
    logic                    w_in_frame;
    logic                    w_start;

    // Odd ratios are rounded down to even so the mid-bit point is exact.
    assign w_p_in       = (Prescale < c_MIN_P) ? c_MIN_P : {Prescale[PRESCALE_W-1:1], 1'b0};
    assign w_half       = r_p >> 1;
    assign w_check      = w_half + PRESCALE_W'(1);
    assign w_last       = r_p - PRESCALE_W'(1);
    assign w_check_edge = (r_edge_cnt == w_check);
    assign w_last_edge  = (r_edge_cnt == w_last);
    assign w_start      = (r_state == S_IDLE) && !RX_IN;

    assign w_in_frame   = (r_state == S_START) || (r_state == S_DATA) ||
                          (r_state == S_PARITY) || (r_state == S_STOP);

    assign data_sample_en = w_in_frame &&
                            ((r_edge_cnt == w_half - PRESCALE_W'(2)) ||
                             (r_edge_cnt == w_half - PRESCALE_W'(1)) ||
                             (r_edge_cnt == w_half));

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!RX_IN) w_next = S_START;
            end
            S_START: begin
                if (w_check_edge && sampled_bit) w_next = S_IDLE;
                else if (w_last_edge)            w_next = S_DATA;
            end
            S_DATA: begin
                if (w_last_edge && (r_bit_cnt == c_LAST_BIT))
                    w_next = r_par_en ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (w_last_edge) w_next = S_STOP;
            end
            // Leaving at mid-stop-bit gives time to catch a back-to-back start.
            S_STOP: begin
                if (w_check_edge) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_edge_cnt  <= '0;
            r_p         <= c_MIN_P;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_en    <= 1'b0;
            r_par_typ   <= 1'b0;
            r_par_fail  <= 1'b0;
            P_DATA      <= '0;
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
            strt_glitch <= 1'b0;

            if (r_state == S_IDLE || w_last_edge) begin
                r_edge_cnt <= '0;
            end else begin
                r_edge_cnt <= r_edge_cnt + PRESCALE_W'(1);
            end

            if (w_start) begin
                r_p        <= w_p_in;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_par_fail <= 1'b0;
                r_bit_cnt  <= '0;
            end

            case (r_state)
                S_START: begin
                    if (w_check_edge && sampled_bit) strt_glitch <= 1'b1;
                    if (w_last_edge)                 r_bit_cnt   <= '0;
                end
                S_DATA: begin
                    if (w_check_edge) r_shift   <= {sampled_bit, r_shift[DATA_WIDTH-1:1]};
                    if (w_last_edge)  r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                end
                S_PARITY: begin
                    if (w_check_edge) r_par_fail <= sampled_bit ^ ((^r_shift) ^ r_par_typ);
                end
                S_STOP: begin
                    if (w_check_edge) begin
                        par_err    <= r_par_fail;
                        stp_err    <= ~sampled_bit;
                        data_valid <= sampled_bit & ~r_par_fail;
                        if (sampled_bit && !r_par_fail) P_DATA <= r_shift;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_ctrl
// Purpose  : Self-checking bench for uart_rx_ctrl with a frame-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_ctrl;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          RX_IN = 1'b1;
    logic          sampled_bit = 1'b1;
    logic [PW-1:0] Prescale = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic          data_sample_en;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          strt_glitch;
    logic          busy;

    uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .RX_IN          (RX_IN),
        .sampled_bit    (sampled_bit),
        .Prescale       (Prescale),
        .PAR_EN         (PAR_EN),
        .PAR_TYP        (PAR_TYP),
        .data_sample_en (data_sample_en),
        .P_DATA         (P_DATA),
        .data_valid     (data_valid),
        .par_err        (par_err),
        .stp_err        (stp_err),
        .strt_glitch    (strt_glitch),
        .busy           (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Three-sample majority sampler feeding the sequencer.
    logic [1:0] smp = 2'b11;
    always @(posedge CLK) begin
        if (data_sample_en) begin
            smp         <= {smp[0], RX_IN};
            sampled_bit <= (smp[1] & smp[0]) | (smp[1] & RX_IN) | (smp[0] & RX_IN);
        end
    end

    // Expected events keyed by cycle number.
    bit            ev_dv[int];
    bit            ev_pe[int];
    bit            ev_se[int];
    bit            ev_gl[int];
    bit            ev_busy[int];
    bit            ev_clr[int];
    logic [DW-1:0] ev_pd[int];
    logic [DW-1:0] mdl_pd = '0;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mon_en) begin
            if (ev_clr.exists(cyc)) mdl_pd = '0;
            if (ev_pd.exists(cyc))  mdl_pd = ev_pd[cyc];
            chk("data_valid",  32'(data_valid),  32'(ev_dv.exists(cyc)));
            chk("par_err",     32'(par_err),     32'(ev_pe.exists(cyc)));
            chk("stp_err",     32'(stp_err),     32'(ev_se.exists(cyc)));
            chk("strt_glitch", 32'(strt_glitch), 32'(ev_gl.exists(cyc)));
            chk("busy",        32'(busy),        32'(ev_busy.exists(cyc)));
            chk("P_DATA",      32'(P_DATA),      32'(mdl_pd));
            if (!ev_busy.exists(cyc)) chk("dse_idle", 32'(data_sample_en), 32'd0);
        end
    end

    function automatic int eff_p(input int ps);
        return (ps < 8) ? 8 : (ps & ~1);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic sched_frame(input int k, input int p, input bit pe,
                               input logic [DW-1:0] d, input bit pf, input bit sf);
        int h   = p / 2;
        int lat = 1 + p + DW * p + (pe ? p : 0) + h + 2;
        for (int c = k + 1; c <= k + lat; c++) ev_busy[c] = 1'b1;
        if (pf) ev_pe[k + lat] = 1'b1;
        if (sf) ev_se[k + lat] = 1'b1;
        if (!pf && !sf) begin
            ev_dv[k + lat] = 1'b1;
            ev_pd[k + lat] = d;
        end
    endtask

    // Caller is always positioned 1 time unit after a rising edge.
    task automatic drive_frame(input logic [DW-1:0] d, input int ps, input bit pe, input bit pt,
                               input bit bad_par, input bit bad_stop, input int gap);
        int p = eff_p(ps);
        int h = p / 2;
        int g = gap;
        int k;
        bit par;
        par = pt ? ~(^d) : (^d);
        if (bad_par) par = ~par;
        if (bad_stop && g < 1) g = 1;
        Prescale = PW'(ps);
        PAR_EN   = pe;
        PAR_TYP  = pt;
        RX_IN    = 1'b0;
        k        = cyc;
        sched_frame(k, p, pe, d, pe && bad_par, bad_stop);
        step();
        Prescale = PW'($urandom);
        PAR_EN   = 1'($urandom);
        PAR_TYP  = 1'($urandom);
        repeat (p - 1) step();
        for (int i = 0; i < DW; i++) begin
            RX_IN = d[i];
            repeat (p) step();
        end
        if (pe) begin
            RX_IN = par;
            repeat (p) step();
        end
        RX_IN = ~bad_stop;
        repeat (bad_stop ? h + 3 : p) step();
        RX_IN = 1'b1;
        repeat (g) step();
    endtask

    task automatic drive_glitch(input int ps, input int low, input int gap);
        int p = eff_p(ps);
        int h = p / 2;
        int k;
        Prescale = PW'(ps);
        RX_IN    = 1'b0;
        k        = cyc;
        for (int c = k + 1; c <= k + h + 2; c++) ev_busy[c] = 1'b1;
        ev_gl[k + h + 3] = 1'b1;
        repeat (low) step();
        RX_IN = 1'b1;
        while (cyc < k + h + 3) step();
        repeat (gap) step();
    endtask

    int            pss[8] = '{8, 16, 32, 9, 17, 5, 0, 33};
    int            ps_r;
    int            p_r;
    bit            pe_r;
    bit            pt_r;
    int            k0;
    logic [DW-1:0] d_r;

    initial begin
        RST = 1'b1;
        repeat (3) step();
        RST    = 1'b0;
        mon_en = 1'b1;
        chk("rst_busy",  32'(busy),           32'd0);
        chk("rst_pdata", 32'(P_DATA),         32'd0);
        chk("rst_dv",    32'(data_valid),     32'd0);
        chk("rst_dse",   32'(data_sample_en), 32'd0);
        step();

        drive_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        drive_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 1'b0, 3);
        drive_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        drive_glitch(8, 3, 2);
        drive_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        drive_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b0, 3);

        // Abort a frame with reset while bit 4 is being received.
        d_r      = 8'hC3;
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        RX_IN    = 1'b0;
        k0       = cyc;
        for (int c = k0 + 1; c <= k0 + 5 * 8 + 3; c++) ev_busy[c] = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 4; i++) begin
            RX_IN = d_r[i];
            repeat (8) step();
        end
        RX_IN = d_r[4];
        repeat (3) step();
        RST   = 1'b1;
        RX_IN = 1'b1;
        ev_clr[cyc + 1] = 1'b1;
        step();
        RST = 1'b0;
        chk("midrst_busy",  32'(busy),        32'd0);
        chk("midrst_pdata", 32'(P_DATA),      32'd0);
        chk("midrst_dv",    32'(data_valid),  32'd0);
        chk("midrst_gl",    32'(strt_glitch), 32'd0);
        step();
        drive_frame(8'h0F, 8, 1'b1, 1'b1, 1'b0, 1'b0, 2);

        for (int i = 0; i < 50; i++) begin
            ps_r = pss[$urandom_range(0, 7)];
            p_r  = eff_p(ps_r);
            if ($urandom_range(0, 5) == 0) begin
                drive_glitch(ps_r, $urandom_range(1, p_r / 2 - 1), $urandom_range(0, 3));
            end else begin
                pe_r = 1'($urandom);
                pt_r = 1'($urandom);
                d_r  = DW'($urandom);
                drive_frame(d_r, ps_r, pe_r, pt_r, pe_r && ($urandom_range(0, 3) == 0),
                            ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
            end
        end

        repeat (12) step();
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART Rx path.
- Detects the start bit and times each bit period with an oversampling edge counter.
- Drives the 3-sample majority data sampler through data_sample_en and consumes its registered sampled_bit.
- Deserialises LSB-first data, checks parity and the stop bit, and emits the received byte with a one-cycle valid pulse and error flags.
- Sits between the RX_IN pin synchroniser and the byte consumer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_W, 6, width of the Prescale input (oversampling ratio)

Ports:
CLK  in  1  clock; all logic on posedge
RST  in  1  reset, synchronous and active-high
RX_IN  in  1  serial line, already synchronised, idle high
sampled_bit  in  1  majority-voted bit from the data sampler (registered there)
Prescale  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
PAR_EN  in  1  1 = frame carries a parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
data_sample_en  out  1  sampler shift enable
P_DATA  out  DATA_WIDTH  last good received word
data_valid  out  1  one-cycle pulse: P_DATA updated
par_err  out  1  one-cycle pulse: parity mismatch
stp_err  out  1  one-cycle pulse: stop bit sampled 0
strt_glitch  out  1  one-cycle pulse: start bit rejected
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (RST=1 at posedge):
  - state goes to IDLE; edge_cnt, bit_cnt and the shift register clear.
  - All outputs go to 0, including P_DATA.
  - Reset mid-frame abandons the frame with no pulses.
- Config latch:
  - Prescale, PAR_EN and PAR_TYP are latched on the IDLE->START transition and are stable for the whole frame.
  - The latched Prescale has its LSB forced to 0; values below 8 are replaced by 8.
  - Call the latched value P.
- edge_cnt:
  - Counts 0..P-1 within each bit period, then wraps to 0 together with the state/bit advance.
  - It is cleared on entry to START.
- Sampling:
  - data_sample_en=1 when edge_cnt is P/2-2, P/2-1 or P/2, in states START, DATA, PARITY and STOP.
  - It is combinational from state and edge_cnt.
  - The check edge is edge_cnt = P/2+1; sampled_bit is consumed only there.
- States and transitions:
  - IDLE: if RX_IN=0, go to START with edge_cnt=0 in the next cycle.
  - START:
    - At the check edge, if sampled_bit=1: pulse strt_glitch and go to IDLE.
    - At edge P-1: go to DATA with bit_cnt=0.
  - DATA:
    - At the check edge: shift register <= {sampled_bit, shift[DATA_WIDTH-1:1]} (LSB first).
    - At edge P-1: if bit_cnt=DATA_WIDTH-1, go to PARITY when PAR_EN else STOP; otherwise bit_cnt+1.
  - PARITY:
    - At the check edge: par_fail <= sampled_bit XOR (^shift XOR PAR_TYP).
    - At edge P-1: go to STOP.
  - STOP:
    - At the check edge: stp_fail <= ~sampled_bit, then go to DONE.
    - The half-bit early exit permits back-to-back frames.
  - DONE (exactly 1 cycle), then IDLE:
    - par_err = par_fail and stp_err = stp_fail.
    - If neither fails: P_DATA <= shift and data_valid=1.
    - If either fails: P_DATA is unchanged.
- Output timing:
  - data_valid, par_err and stp_err are registered and asserted only during the DONE cycle.
  - strt_glitch is asserted for the single cycle after the rejecting check edge.
- RX_IN is ignored outside IDLE; the line level is seen only via sampled_bit.
- par_fail is cleared on START entry, so with PAR_EN=0 par_err is never set.
- Latency for a good frame, where t0 is the IDLE cycle that sees RX_IN=0:
  - data_valid at t0 + 1 + P + DATA_WIDTH*P + PAR_EN*P + (P/2+2).
  - For P=8, DATA_WIDTH=8, PAR_EN=1 this is t0+87.

Test Plan:
- Prescale=8, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> data_valid pulses 1 cycle at t0+87, P_DATA=0xA5, par_err=0, stp_err=0.
- Same frame with the parity bit driven 1 -> par_err=1 at t0+87, data_valid=0, P_DATA keeps its previous value.
- Prescale=16, PAR_EN=0, 0x3C with the stop bit driven 0 -> stp_err=1 at t0+1+16+128+10=t0+155, data_valid=0.
- RX_IN low for 3 cycles then high, Prescale=8 -> strt_glitch pulses once, state returns to IDLE, busy=0, no data_valid.
- Two back-to-back frames 0x55 then 0xAA, Prescale=8, PAR_EN=0, second start edge immediately after the stop bit -> two data_valid pulses, P_DATA=0x55 then 0xAA.
- RST=1 asserted in DATA at bit 4 -> next cycle all outputs 0 and busy=0; a following clean 0x0F frame is received correctly.
